// File: rtl/generador_tono_pkg.sv
// generador_tono_pkg
// Shared definitions for the tone generator and sibling audio blocks:
// FSM state encoding, default timing parameters and the system clock rate.
package generador_tono_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int unsigned CNT_W         = 32;
  localparam int unsigned CLK_HZ        = 12_000_000;
  localparam int unsigned NOTE_CYC_DEF  = 3_600_000;  // 300 ms @ 12 MHz
  localparam int unsigned GAP_CYC_DEF   = 600_000;    // 50 ms @ 12 MHz
  localparam int unsigned LOAD_WAIT_DEF = 2;          // covers two upstream register stages

endpackage

// File: rtl/divisor_tono.sv
// divisor_tono
// Loadable half-period counter driving a square wave.
// Ports:
//   clk, reset      system clock, async active-high reset
//   i_load          latch i_div into the held divisor this cycle
//   i_div           half-period in clk cycles, 0 = rest
//   i_clear         clear counter and force the wave low (wins over i_run)
//   i_run           advance the counter this cycle
//   o_spk           square-wave output (registered)
module divisor_tono
  import generador_tono_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_clear,
  input  logic             i_run,
  output logic             o_spk
);

  logic [CNT_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_hc;
  logic             r_spk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_q <= '0;
      r_hc    <= '0;
      r_spk   <= 1'b0;
    end else begin
      if (i_load) begin
        r_div_q <= i_div;
      end
      if (i_clear) begin
        r_hc  <= '0;
        r_spk <= 1'b0;
      end else if (i_run && (r_div_q != '0)) begin
        // Guarding on a non-zero divisor keeps r_div_q-1 from wrapping;
        // a rest simply leaves hc at 0 and the wave low.
        if (r_hc == (r_div_q - 1'b1)) begin
          r_hc  <= '0;
          r_spk <= ~r_spk;
        end else begin
          r_hc <= r_hc + 1'b1;
        end
      end
    end
  end

  assign o_spk = r_spk;

endmodule

// File: rtl/generador_tono.sv
// generador_tono
// Turns the per-note half-period divisor into a buzzer square wave and
// paces the melody: LOAD (wait for upstream), PLAY (tone), GAP (silence),
// then a one-cycle note_tick so the sequencer advances.
//
// state | meaning
// IDLE  | stopped, waiting for enable
// LOAD  | waiting LOAD_WAIT cycles for divisor, latched on the last one
// PLAY  | tone output for NOTE_CYC cycles
// GAP   | silent GAP_CYC cycles, note_tick on the last one
//
// Ports:
//   clk, reset      12 MHz system clock, async active-high reset
//   i_enable        run melody; 0 aborts to IDLE
//   i_divisor       half-period in clk cycles, 0 = rest
//   o_spk           square-wave speaker drive
//   o_note_tick     one-cycle request for the next note
//   o_playing       high while in PLAY
module generador_tono
  import generador_tono_pkg::*;
#(
  parameter int unsigned NOTE_CYC  = NOTE_CYC_DEF,
  parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
  parameter int unsigned LOAD_WAIT = LOAD_WAIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_divisor,
  output logic             o_spk,
  output logic             o_note_tick,
  output logic             o_playing
);

  localparam logic [CNT_W-1:0] L_NOTE_M1 = CNT_W'(NOTE_CYC - 1);
  localparam logic [CNT_W-1:0] L_GAP_M1  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] L_LOAD_M1 = CNT_W'(LOAD_WAIT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tick;
  logic             r_playing;
  logic             w_load;
  logic             w_run;
  logic             w_clear;
  logic             w_spk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_playing <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      // Outputs are registered from the next-state view so they line up
      // exactly with the state they describe.
      r_playing <= (w_state_nxt == PLAY);
      r_tick    <= (w_state_nxt == GAP) && (w_cnt_nxt == L_GAP_M1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (i_enable) w_state_nxt = LOAD;
      LOAD: begin
        if (!i_enable)               w_state_nxt = IDLE;
        else if (r_cnt == L_LOAD_M1) w_state_nxt = PLAY;
      end
      PLAY: begin
        if (!i_enable)               w_state_nxt = IDLE;
        else if (r_cnt == L_NOTE_M1) w_state_nxt = GAP;
      end
      GAP: begin
        if (!i_enable)               w_state_nxt = IDLE;
        else if (r_cnt == L_GAP_M1)  w_state_nxt = LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase

    // One shared counter: restarts on every state change, idles at 0.
    if ((w_state_nxt != r_state) || (w_state_nxt == IDLE)) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Tone counter only runs while staying in PLAY; every other transition
  // (entry, exit to GAP, abort) clears it and forces the wave low.
  assign w_load  = (r_state == LOAD) && (w_state_nxt == PLAY);
  assign w_run   = (r_state == PLAY) && (w_state_nxt == PLAY);
  assign w_clear = !w_run;

  divisor_tono u_divisor_tono (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_div   (i_divisor),
    .i_clear (w_clear),
    .i_run   (w_run),
    .o_spk   (w_spk)
  );

  assign o_spk       = w_spk;
  assign o_note_tick = r_tick;
  assign o_playing   = r_playing;

endmodule

// File: tb/tb_generador_tono.sv
// Bench for generador_tono with NOTE_CYC=40, GAP_CYC=6, LOAD_WAIT=2.
// Sample s is taken 1 ns after rising edge s counted from enable.
// Expected first note: LOAD at samples 1-2, PLAY 3-42, GAP 43-48
// (tick at 48), next LOAD 49-50, next PLAY from 51.
module tb_generador_tono;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] divisor = 32'd0;
  logic        spk;
  logic        note_tick;
  logic        playing;

  int n_checks = 0;
  int n_errors = 0;

  localparam int TR_LEN = 60;

  typedef struct {
    int div;
    int div_mid;
    int exp_changes;
    int exp_first_hi;
  } vec_t;

  vec_t vecs[6];
  logic tr_spk  [0:TR_LEN];
  logic tr_play [0:TR_LEN];
  logic tr_tick [0:TR_LEN];

  generador_tono #(
    .NOTE_CYC  (40),
    .GAP_CYC   (6),
    .LOAD_WAIT (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_enable    (enable),
    .i_divisor   (divisor),
    .o_spk       (spk),
    .o_note_tick (note_tick),
    .o_playing   (playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    divisor = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int chg, first_hi, first_hi2, pcnt, first_play, second_play;
    int tcnt, tidx, gap_hi, ticks;

    // divisor, mid-PLAY divisor, spk changes in samples 2..50, first high sample
    vecs[0] = '{div: 5,  div_mid: 5,  exp_changes: 8,  exp_first_hi: 8};
    vecs[1] = '{div: 0,  div_mid: 0,  exp_changes: 0,  exp_first_hi: 0};
    vecs[2] = '{div: 1,  div_mid: 7,  exp_changes: 40, exp_first_hi: 4};
    vecs[3] = '{div: 3,  div_mid: 3,  exp_changes: 14, exp_first_hi: 6};
    vecs[4] = '{div: 40, div_mid: 40, exp_changes: 0,  exp_first_hi: 0};
    vecs[5] = '{div: 2,  div_mid: 9,  exp_changes: 20, exp_first_hi: 5};

    // Outputs while reset is held
    repeat (2) @(posedge clk);
    #1;
    check("reset_spk", int'(spk), 0);
    check("reset_tick", int'(note_tick), 0);
    check("reset_playing", int'(playing), 0);

    // Table-driven full-note traces
    for (int i = 0; i < 6; i++) begin
      do_reset();
      divisor = 32'(vecs[i].div);
      enable  = 1'b1;
      for (int s = 1; s <= TR_LEN; s++) begin
        step();
        tr_spk[s]  = spk;
        tr_play[s] = playing;
        tr_tick[s] = note_tick;
        if (s == 20) divisor = 32'(vecs[i].div_mid);
        if (s == 48) divisor = 32'd9;   // decoy: must not be latched
        if (s == 50) divisor = 32'd4;   // present at the sampling edge 51
      end
      chg = 0; first_hi = 0; pcnt = 0; first_play = 0; second_play = 0;
      tcnt = 0; tidx = 0; gap_hi = 0; first_hi2 = 0;
      for (int s = 1; s <= 50; s++) begin
        if (s >= 2 && tr_spk[s] != tr_spk[s-1]) chg++;
        if (tr_spk[s] && first_hi == 0) first_hi = s;
        if (tr_play[s]) begin
          pcnt++;
          if (first_play == 0) first_play = s;
        end
        if (tr_tick[s]) begin
          tcnt++;
          tidx = s;
        end
        if (s >= 43 && s <= 48 && tr_spk[s]) gap_hi++;
      end
      for (int s = 43; s <= TR_LEN; s++) begin
        if (tr_play[s] && second_play == 0) second_play = s;
        if (s >= 51 && tr_spk[s] && first_hi2 == 0) first_hi2 = s;
      end
      check($sformatf("v%0d_spk_changes", i), chg, vecs[i].exp_changes);
      check($sformatf("v%0d_first_spk_high", i), first_hi, vecs[i].exp_first_hi);
      check($sformatf("v%0d_playing_cycles", i), pcnt, 40);
      check($sformatf("v%0d_play_entry", i), first_play, 3);
      check($sformatf("v%0d_gap_spk_high", i), gap_hi, 0);
      check($sformatf("v%0d_tick_count", i), tcnt, 1);
      check($sformatf("v%0d_tick_pos", i), tidx, 48);
      check($sformatf("v%0d_next_play_entry", i), second_play, 51);
      check($sformatf("v%0d_next_note_first_high", i), first_hi2, 55);
    end

    // Enable drops mid-PLAY while spk is high, then re-enable
    do_reset();
    divisor = 32'd3;
    enable  = 1'b1;
    for (int s = 1; s <= 20; s++) step();
    check("abort_pre_spk", int'(spk), 1);
    enable = 1'b0;
    step();
    check("abort_spk", int'(spk), 0);
    check("abort_playing", int'(playing), 0);
    check("abort_tick", int'(note_tick), 0);
    ticks = 0;
    for (int s = 22; s <= 24; s++) begin
      step();
      if (note_tick) ticks++;
    end
    check("abort_idle_playing", int'(playing), 0);
    check("abort_idle_ticks", ticks, 0);
    enable = 1'b1;
    step(); check("reen_load1_playing", int'(playing), 0);
    step(); check("reen_load2_playing", int'(playing), 0);
    step(); check("reen_play_playing", int'(playing), 1);
    step(); step();
    check("reen_spk_before_first", int'(spk), 0);
    step();
    check("reen_spk_first", int'(spk), 1);

    // Enable drops in the final GAP cycle: pending tick is dropped
    do_reset();
    divisor = 32'd2;
    enable  = 1'b1;
    for (int s = 1; s <= 47; s++) step();
    enable = 1'b0;
    ticks = 0;
    for (int s = 48; s <= 55; s++) begin
      step();
      if (note_tick) ticks++;
    end
    check("gap_abort_ticks", ticks, 0);

    // Async reset mid-PLAY while spk is high
    do_reset();
    divisor = 32'd5;
    enable  = 1'b1;
    for (int s = 1; s <= 10; s++) step();
    check("areset_pre_spk", int'(spk), 1);
    #2 reset = 1'b1;
    #1;
    check("areset_play_spk", int'(spk), 0);
    check("areset_play_playing", int'(playing), 0);

    // Async reset one cycle before the tick
    @(posedge clk);
    #1 reset = 1'b0;
    for (int s = 1; s <= 47; s++) step();
    #2 reset = 1'b1;
    #1;
    check("areset_gap_spk", int'(spk), 0);
    check("areset_gap_tick", int'(note_tick), 0);
    check("areset_gap_playing", int'(playing), 0);
    ticks = 0;
    repeat (2) begin
      step();
      if (note_tick) ticks++;
    end
    reset = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (note_tick) ticks++;
    end
    check("areset_gap_no_tick", ticks, 0);
    check("areset_restart_playing", int'(playing), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/generador_tono.md
# generador_tono

Converts the per-note half-period divisor from the note sequencer into an audible square wave for the buzzer, and paces the melody. Each note is held for a fixed time and followed by a short silent articulation gap. It then emits a one-cycle `note_tick` so the upstream sequencer advances. It sits between the note sequencer and the speaker pin, in the 12 MHz domain.

## Interface
- `NOTE_CYC`, default 3_600_000: note duration in clk cycles (300 ms @ 12 MHz); must be ≥1.
- `GAP_CYC`, default 600_000: silent gap after each note, in cycles (50 ms); must be ≥1.
- `LOAD_WAIT`, default 2: cycles spent in LOAD before sampling `divisor`, covering upstream register latency; must be ≥1.
- `clk`  in  1  system clock, 12 MHz.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  run melody; 0 aborts to IDLE.
- `divisor`  in  32  half-period in clk cycles (12 MHz / (2·f_note)); 0 = rest.
- `spk`  out  1  square-wave speaker drive.
- `note_tick`  out  1  one-cycle pulse requesting the next note.
- `playing`  out  1  high while in PLAY.

## Operation
- States: IDLE, LOAD, PLAY, GAP.
- Reset (async): state=IDLE, `spk`=0, `note_tick`=0, `playing`=0, latched divisor `div_q`=0, all counters 0.
- IDLE → LOAD when `enable`=1. No tick is issued for the first note; the current upstream value is used.
- LOAD lasts exactly `LOAD_WAIT` cycles. On its last cycle, `divisor` is latched into `div_q`. Next state is PLAY, with the half-period counter `hc`=0, the duration counter=0, and `spk`=0.
- PLAY lasts exactly `NOTE_CYC` cycles. `hc` increments each cycle. When `hc`==`div_q`−1, `hc` is cleared to 0 and `spk` toggles.
  - Resulting period is 2·`div_q` cycles (e.g. 22900 → 262 Hz).
  - `div_q`==0: rest; `spk` stays 0 and `hc` holds 0.
  - `div_q`==1: `spk` toggles every cycle.
  - Changes on `divisor` during PLAY or GAP are ignored.
- PLAY → GAP after `NOTE_CYC` cycles. `spk` is forced to 0 on entry and held 0 throughout GAP.
- GAP lasts exactly `GAP_CYC` cycles. `note_tick`=1 only during the final GAP cycle. Next state is LOAD.
- `enable`=0 in any non-IDLE state: next cycle is IDLE with `spk`=0, `playing`=0, `note_tick`=0, and counters cleared. A tick pending in that cycle is dropped.
- Counters are 32-bit unsigned. `hc` compares against `div_q`−1 only when `div_q`≠0, so no underflow path exists.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `playing` is high for exactly `NOTE_CYC` consecutive cycles per note.
- First `spk` edge occurs on the `div_q`-th clk edge after PLAY entry.
- Note-to-note period is `LOAD_WAIT` + `NOTE_CYC` + `GAP_CYC` cycles.
- `note_tick` precedes the next divisor sample by exactly `LOAD_WAIT`+1 edges. The upstream sequencer has two register stages (index, then value), so a `LOAD_WAIT` of 2 suffices.
- Reset mid-operation takes effect asynchronously. The block restarts from IDLE with no tick.

## Structure
- Shared package holds: state enum (IDLE, LOAD, PLAY, GAP, 2-bit), default `NOTE_CYC`/`GAP_CYC`/`LOAD_WAIT`, and `CLK_HZ`=12_000_000 for sibling audio blocks.
- One sub-module, `divisor_tono`, is natural: a loadable half-period counter with toggle output, clear input and rest handling. The FSM, duration/gap counters and tick generation stay in `generador_tono`.

## Test plan
All tests use `NOTE_CYC`=40, `GAP_CYC`=6, `LOAD_WAIT`=2.
- **Divisor 5, enable=1:** `playing` is high for 40 cycles, first `spk` toggle 5 edges after PLAY entry, then every 5 cycles (8 toggles), and `spk`=0 on GAP entry.
- **Gap and tick:** `spk`=0 for 6 cycles after PLAY; `note_tick` is a single 1-cycle pulse in the 6th GAP cycle; `divisor` is sampled 3 edges later; total note cycle is 48.
- **Divisor 0 (rest):** `spk` stays 0 for the whole note; `playing` and `note_tick` timing are unchanged.
- **Divisor 1, `divisor` changed to 7 mid-PLAY:** `spk` toggles every cycle for the whole note, and the new value is ignored until the next LOAD.
- **Enable drops mid-PLAY:** IDLE on the next cycle with `spk`=0 and no `note_tick`. Re-enabling restarts LOAD with the full 2-cycle wait.
- **Async reset mid-GAP, one cycle before the tick:** all outputs go to 0 immediately and no `note_tick` is ever emitted for that note.
